// File: rtl/mem_arbiter_if.sv
// External memory port bundle: one transaction at a time, completed by bus_ack.
// The arbiter drives the master side; the memory controller is the slave.
interface mem_arbiter_if;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wen, bus_addr, bus_wdata, bus_wmask,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wen, bus_addr, bus_wdata, bus_wmask,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and the mem stage.
// The mem stage has priority, bounded by a fetch anti-starvation counter.
module mem_arbiter #(
    parameter int          MEM_BURST_MAX = 4,
    parameter logic [31:0] RESET_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    input  logic        fe_flush,
    output logic        fe_ack,
    output logic [31:0] fe_data,

    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,

    mem_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MEM_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FE_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             grant_mem;
    logic             grant_fe;
    logic             squash;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_full;

    assign starve_full = (starve_cnt == CNT_MAX);

    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_fe   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req && !(fe_req && starve_full)) begin
                    grant_mem  = 1'b1;
                    state_next = MEM_BUSY;
                end else if (fe_req && !fe_flush) begin
                    grant_fe   = 1'b1;
                    state_next = FE_BUSY;
                end
            end
            FE_BUSY, MEM_BUSY: begin
                if (bus.bus_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Acks are routed combinationally on the bus_ack cycle; a redirect landing
    // on that same cycle still kills the fetch response.
    assign fe_ack    = !reset && bus.bus_ack && (state == FE_BUSY) && !squash && !fe_flush;
    assign mem_ack   = !reset && bus.bus_ack && (state == MEM_BUSY);
    assign fe_data   = bus.bus_rdata;
    assign mem_rdata = bus.bus_rdata;
    assign bus.bus_req = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: reset is synchronous, so an abort mid-transaction simply
            // returns to IDLE on this edge and bus_req falls with it.
            state         <= IDLE;
            squash        <= 1'b0;
            starve_cnt    <= '0;
            bus.bus_wen   <= 1'b0;
            bus.bus_addr  <= RESET_ADDR;
            bus.bus_wdata <= '0;
            bus.bus_wmask <= '0;
        end else begin
            state <= state_next;

            if (grant_mem) begin
                bus.bus_wen   <= mem_wen;
                bus.bus_addr  <= mem_addr;
                bus.bus_wdata <= mem_wdata;
                bus.bus_wmask <= mem_wen ? mem_wmask : 4'b0000;
            end else if (grant_fe) begin
                bus.bus_wen   <= 1'b0;
                bus.bus_addr  <= fe_addr;
                bus.bus_wmask <= 4'b0000;
            end

            if (state_next == IDLE)
                squash <= 1'b0;
            else if (state == FE_BUSY && fe_flush)
                squash <= 1'b1;

            // Counts mem grants that overtook a waiting fetch.
            if (grant_fe || (state == IDLE && !fe_req))
                starve_cnt <= '0;
            else if (grant_mem && fe_req && !starve_full)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int          MAXB  = 2;
    localparam logic [31:0] RST_A = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe_req, fe_flush, fe_ack;
    logic [31:0] fe_addr, fe_data;
    logic        mem_req, mem_wen, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_BURST_MAX(MAXB), .RESET_ADDR(RST_A)) dut (
        .clk      (clk),
        .reset    (reset),
        .fe_req   (fe_req),
        .fe_addr  (fe_addr),
        .fe_flush (fe_flush),
        .fe_ack   (fe_ack),
        .fe_data  (fe_data),
        .mem_req  (mem_req),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: random read data every cycle, ack after a wait.
    bit mem_auto   = 1'b1;
    bit rand_wait  = 1'b0;
    int fixed_wait = 1;

    initial begin
        int wcnt = 0;
        int cur_wait = 0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                bus.bus_rdata = $urandom();
                if (bus.bus_req !== 1'b1) begin
                    bus.bus_ack = 1'b0;
                    wcnt        = 0;
                    cur_wait    = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
                end else if (wcnt == cur_wait) begin
                    bus.bus_ack = 1'b1;
                    wcnt        = wcnt + 1;
                end else begin
                    bus.bus_ack = 1'b0;
                    wcnt        = wcnt + 1;
                end
            end
        end
    end

    // Reference model: the one outstanding bus transaction as a record.
    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_fe;
    } txn_t;

    bit   m_valid   = 1'b0;
    bit   m_busy    = 1'b0;
    bit   m_flushed = 1'b0;
    int   m_starve  = 0;
    txn_t m_txn;

    logic got_fe, got_mem, got_req, got_bus_ack;
    logic prev_req = 1'b0;
    bit   grants[$];

    // Samples at the falling edge, checks, advances the model across the next
    // rising edge, then returns 1 ns after it so callers can drive inputs.
    task automatic tick();
        bit force_fe;
        @(negedge clk);
        got_fe      = fe_ack;
        got_mem     = mem_ack;
        got_req     = bus.bus_req;
        got_bus_ack = bus.bus_req && bus.bus_ack;
        if (bus.bus_req === 1'b1 && prev_req !== 1'b1) grants.push_back(bus.bus_addr[31]);
        prev_req = bus.bus_req;

        check("fe_data", fe_data, bus.bus_rdata);
        check("mem_rdata", mem_rdata, bus.bus_rdata);
        if (m_valid) begin
            check("bus_req", bus.bus_req, m_busy);
            check("bus_addr", bus.bus_addr, m_txn.addr);
            check("bus_wen", bus.bus_wen, m_txn.wen);
            check("bus_wmask", bus.bus_wmask, m_txn.wmask);
            if (!m_txn.is_fe) check("bus_wdata", bus.bus_wdata, m_txn.wdata);
            check("fe_ack", fe_ack,
                  !reset && m_busy && m_txn.is_fe && bus.bus_ack && !m_flushed && !fe_flush);
            check("mem_ack", mem_ack, !reset && m_busy && !m_txn.is_fe && bus.bus_ack);
        end

        if (reset) begin
            m_valid   = 1'b1;
            m_busy    = 1'b0;
            m_flushed = 1'b0;
            m_starve  = 0;
            m_txn     = '{RST_A, 1'b0, 32'h0, 4'h0, 1'b0};
        end else if (m_valid) begin
            if (m_busy) begin
                if (m_txn.is_fe && fe_flush) m_flushed = 1'b1;
                if (bus.bus_ack) begin
                    m_busy    = 1'b0;
                    m_flushed = 1'b0;
                end
            end else begin
                force_fe = fe_req && (m_starve == MAXB);
                if (mem_req && !force_fe) begin
                    m_txn    = '{mem_addr, mem_wen, mem_wdata, mem_wen ? mem_wmask : 4'h0, 1'b0};
                    m_busy   = 1'b1;
                    m_starve = fe_req ? ((m_starve < MAXB) ? m_starve + 1 : MAXB) : 0;
                end else if (fe_req && !fe_flush) begin
                    m_txn    = '{fe_addr, 1'b0, m_txn.wdata, 4'h0, 1'b1};
                    m_busy   = 1'b1;
                    m_starve = 0;
                end else if (!fe_req) begin
                    m_starve = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until fe_ack is seen (bounded); returns ticks taken, 99 on timeout.
    task automatic wait_fe(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (got_fe) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, backs;
        bit exp_ord[6];

        reset = 1'b1; fe_req = 1'b0; fe_addr = '0; fe_flush = 1'b0;
        mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        idle(2);
        reset = 1'b0;
        idle(1);
        check("rst_bus_addr", bus.bus_addr, RST_A);
        check("rst_bus_req", bus.bus_req, 1'b0);

        // Single fetch, memory acks one cycle after bus_req rises.
        fe_req = 1'b1; fe_addr = 32'h8000_0000;
        wait_fe(n);
        check("fe_latency", 32'(n), 32'd3);
        fe_req = 1'b0;
        idle(2);

        // Store with two wait states.
        fixed_wait = 2;
        idle(1);
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0000_1000;
        mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'b0011;
        cnt = 0;
        for (int i = 0; i < 10 && cnt == 0; i++) begin
            tick();
            if (got_mem) cnt++;
        end
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (got_mem) cnt++;
        end
        check("store_ack_count", 32'(cnt), 32'd1);

        // Both requesters held, zero-wait memory: anti-starvation order.
        fixed_wait = 0;
        idle(1);
        grants.delete();
        fe_req = 1'b1; fe_addr = 32'h8000_1000;
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_2000;
        idle(13);
        fe_req = 1'b0; mem_req = 1'b0;
        idle(3);
        exp_ord = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        check("grant_count", (grants.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            check($sformatf("grant_order[%0d]", i), 32'(grants[i]), 32'(exp_ord[i]));

        // Fetch squashed by a redirect while the bus waits three cycles.
        fixed_wait = 3;
        idle(1);
        fe_req = 1'b1; fe_addr = 32'h8000_2000;
        tick();
        fe_flush = 1'b1; fe_req = 1'b0;
        tick();
        fe_flush = 1'b0;
        cnt = 0; backs = 0;
        for (int i = 0; i < 10 && backs == 0; i++) begin
            tick();
            if (got_fe) cnt++;
            if (got_bus_ack) backs++;
        end
        check("squash_fe_ack", 32'(cnt), 32'd0);
        check("squash_bus_done", 32'(backs), 32'd1);
        idle(1);
        fe_req = 1'b1; fe_addr = 32'h8000_3000;
        wait_fe(n);
        check("post_squash_latency", 32'(n), 32'd5);
        fe_req = 1'b0;
        idle(2);

        // Reset while MEM_BUSY with bus_ack pending, then a stray bus_ack.
        mem_auto = 1'b0;
        bus.bus_ack = 1'b0;
        idle(1);
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_3000;
        idle(2);
        reset = 1'b1; bus.bus_ack = 1'b1;
        tick();
        check("rst_mid_mem_ack", got_mem, 1'b0);
        reset = 1'b0; bus.bus_ack = 1'b0; mem_req = 1'b0;
        tick();
        check("rst_abort_req", got_req, 1'b0);
        bus.bus_ack = 1'b1;
        tick();
        check("stray_mem_ack", got_mem, 1'b0);
        check("stray_fe_ack", got_fe, 1'b0);
        bus.bus_ack = 1'b0;
        mem_auto = 1'b1;
        idle(1);

        // fe_req with fe_flush in IDLE: no grant until the flush drops.
        fe_req = 1'b1; fe_flush = 1'b1; fe_addr = 32'h8000_4000;
        tick();
        check("flush_idle_nogrant", bus.bus_req, 1'b0);
        fe_flush = 1'b0;
        tick();
        check("flush_idle_grant", bus.bus_req, 1'b1);
        wait_fe(n);
        check("flush_idle_ack", (n < 99) ? 32'd1 : 32'd0, 32'd1);
        fe_req = 1'b0;
        idle(1);

        // Random traffic with random memory latency and occasional resets.
        rand_wait = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                fe_req = 1'b0; mem_req = 1'b0; fe_flush = 1'b0;
            end else begin
                if (got_fe || !fe_req) begin
                    fe_req  = $urandom_range(0, 1);
                    fe_addr = 32'h8000_0000 | $urandom();
                end
                fe_flush = ($urandom_range(0, 7) == 0);
                if (got_mem || !mem_req) begin
                    mem_req   = $urandom_range(0, 1);
                    mem_wen   = $urandom_range(0, 1);
                    mem_addr  = $urandom() & 32'h7FFF_FFFF;
                    mem_wdata = $urandom();
                    mem_wmask = 4'($urandom_range(0, 15));
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single external memory port between the fetch stage (instruction reads) and the mem stage (loads/stores). Registers one transaction at a time onto the bus and returns the bus ack and read data to the winning requester. The mem stage has priority, bounded by a fetch anti-starvation counter. An in-flight fetch can be squashed on a pipeline redirect.

Parameters:
MEM_BURST_MAX, 4, max consecutive mem-stage grants while fetch is waiting before fetch is forced a grant (>=1)
RESET_ADDR, 32'h00000000, reset value of bus_addr

Ports:
clk  input  1  clock; one clock; reset is synchronous and active-high
reset  input  1  synchronous active-high reset
fe_req  input  1  fetch read request
fe_addr  input  32  fetch address
fe_flush  input  1  redirect; squash any pending or in-flight fetch
fe_ack  output  1  fetch complete (1-cycle pulse)
fe_data  output  32  fetch read data, valid when fe_ack
mem_req  input  1  mem-stage request
mem_wen  input  1  1=store, 0=load
mem_addr  input  32  mem-stage address
mem_wdata  input  32  store data
mem_wmask  input  4  store byte enables
mem_ack  output  1  mem-stage complete (1-cycle pulse)
mem_rdata  output  32  load data, valid when mem_ack
bus_req  output  1  bus transaction active
bus_wen  output  1  bus write
bus_addr  output  32  bus address
bus_wdata  output  32  bus write data
bus_wmask  output  4  bus byte enables (4'b0000 for reads)
bus_ack  input  1  bus completes current transaction this cycle
bus_rdata  input  32  bus read data, valid with bus_ack

Behaviour:
- States: IDLE, FE_BUSY, MEM_BUSY. Reset -> IDLE; bus_req=0, bus_wen=0, bus_addr=RESET_ADDR, bus_wdata=0, bus_wmask=0, squash=0, starve_cnt=0. fe_ack=mem_ack=0 during reset.
- IDLE, cycle N: arbitrate. Grant mem if mem_req && !(fe_req && starve_cnt==MEM_BURST_MAX). Else grant fetch if fe_req && !fe_flush. On grant, register addr/wen/wdata/wmask (fetch: wen=0, wmask=0) and enter the BUSY state. bus_req=1 from N+1.
- BUSY: bus_* outputs held stable until bus_ack. Requester inputs are ignored after the grant.
- On the bus_ack cycle: bus_req drops next cycle and the state returns to IDLE. No back-to-back grant: minimum one IDLE cycle between transactions, so throughput is at most 1 transaction per 2 cycles.
- Ack routing is combinational on the bus_ack cycle: fe_ack = bus_ack & FE_BUSY & !squash & !fe_flush; mem_ack = bus_ack & MEM_BUSY. fe_data and mem_rdata are both driven from bus_rdata at all times.
- Squash: fe_flush in FE_BUSY sets squash. The transaction still completes on the bus, but fe_ack is suppressed. squash clears on return to IDLE. fe_flush on the bus_ack cycle also suppresses fe_ack.
- starve_cnt (width clog2(MEM_BURST_MAX+1)):
  - increments on a mem grant while fe_req=1, saturating at MEM_BURST_MAX;
  - clears on any fetch grant, or in IDLE when fe_req=0;
  - holds otherwise.
- Simultaneous fe_req+mem_req with starve_cnt<MEM_BURST_MAX: mem wins.
- Mem transactions are never squashed. fe_flush has no effect in MEM_BUSY or on mem arbitration.
- Reset mid-transaction: the state machine aborts to IDLE, bus_req drops the next cycle, and no ack is issued. A bus_ack arriving in IDLE is ignored.
- Requesters hold req until their ack. Dropping req after the grant does not cancel the transaction.

Test Plan:
- fe_req=1, fe_addr=0x80000000, memory acks 1 cycle after bus_req -> bus_req N+1..N+2, bus_addr=0x80000000, bus_wen=0; fe_ack pulse at N+2 with fe_data=bus_rdata; mem_ack stays 0.
- mem_req store, addr=0x1000, wdata=0xDEADBEEF, wmask=4'b0011 -> bus_wen=1 and bus_wmask=4'b0011 held until bus_ack; single mem_ack pulse.
- fe_req and mem_req both held, MEM_BURST_MAX=2, zero-wait memory -> grant order mem, mem, fe, mem, mem, fe; never 3 consecutive mem grants.
- Fetch granted, fe_flush pulsed while bus waits 3 cycles -> bus transaction completes, fe_ack never asserts. Next fetch granted normally with squash cleared.
- reset asserted while MEM_BUSY with bus_ack pending -> next cycle bus_req=0 in IDLE; a later stray bus_ack produces no mem_ack or fe_ack.
- fe_req=1 and fe_flush=1 in the same IDLE cycle, no mem_req -> no grant that cycle; grant the following cycle once fe_flush=0.
